// File: rtl/seq_mult_ctrl_if.sv
// Operand/result handshake bundle for the shift-and-add multiplier.
// master issues start with operands; slave reports ready/busy/done/product.
interface seq_mult_ctrl_if #(
  parameter int WIDTH = 4
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               ready;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, a, b,
    input  ready, busy, done, product
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, product
  );
endinterface

// File: rtl/seq_mult_ctrl.sv
// Unsigned shift-and-add multiplier sequencer.
// One WIDTH-bit ripple-carry adder is reused for WIDTH iterations.
module seq_mult_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  seq_mult_ctrl_if.slave    bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_acc_hi;
  logic [WIDTH-1:0]   r_acc_lo;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_product;

  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH:0]     w_carry;
  logic [WIDTH-1:0]   w_hi_nxt;
  logic [WIDTH-1:0]   w_lo_nxt;
  logic               w_accept;
  logic               w_last;

  assign w_addend   = r_acc_lo[0] ? r_mcand : '0;
  assign w_carry[0] = 1'b0;

  // Full-adder cells; the final carry becomes the new acc_hi MSB.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign w_sum[i]     = r_acc_hi[i] ^ w_addend[i] ^ w_carry[i];
    assign w_carry[i+1] = (r_acc_hi[i] & w_addend[i])
                        | (r_acc_hi[i] & w_carry[i])
                        | (w_addend[i] & w_carry[i]);
  end

  assign w_hi_nxt = {w_carry[WIDTH], w_sum[WIDTH-1:1]};
  assign w_lo_nxt = {w_sum[0], r_acc_lo[WIDTH-1:1]};
  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (bus.start) w_next = S_RUN;
      S_RUN:  if (w_last)    w_next = S_DONE;
      S_DONE:                w_next = S_IDLE;
      default:               w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand   <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_mcand   <= bus.a;
      r_acc_hi  <= '0;
      r_acc_lo  <= bus.b;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (r_state == S_RUN) begin
      r_acc_hi <= w_hi_nxt;
      r_acc_lo <= w_lo_nxt;
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) r_product <= {w_hi_nxt, w_lo_nxt};
    end
  end

  assign bus.ready   = (r_state == S_IDLE);
  assign bus.busy    = (r_state == S_RUN);
  assign bus.done    = (r_state == S_DONE);
  assign bus.product = r_product;
endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed and exhaustive checks for seq_mult_ctrl at WIDTH=4.
// Expected products come from hand tables and a*b.
module tb_seq_mult_ctrl;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  int   cyc;

  seq_mult_ctrl_if #(.WIDTH(4)) bus ();

  seq_mult_ctrl #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec_t;

  vec_t tv [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!bus.ready && k < 20) begin
      step();
      k++;
    end
    if (!bus.ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    wait_ready();
    bus.start = 1'b1;
    bus.a     = v.a;
    bus.b     = v.b;
    step();
    bus.start = 1'b0;
    bus.a     = ~v.a;
    bus.b     = ~v.b;
    for (int k = 0; k < 4; k++) begin
      chk({nm, "_busy"}, int'(bus.busy), 1);
      chk({nm, "_nodone"}, int'(bus.done), 0);
      step();
    end
    chk({nm, "_done"}, int'(bus.done), 1);
    chk({nm, "_prod"}, int'(bus.product), int'(v.p));
    step();
    chk({nm, "_ready"}, int'(bus.ready), 1);
    chk({nm, "_done_off"}, int'(bus.done), 0);
    chk({nm, "_hold"}, int'(bus.product), int'(v.p));
  endtask

  initial begin
    int ndone;
    int prev_acc;
    int acc;
    int k;
    logic [7:0] pr;

    n_cmp = 0;
    n_err = 0;
    tv[0] = '{4'd3,  4'd5,  8'd15};
    tv[1] = '{4'd15, 4'd15, 8'd225};
    tv[2] = '{4'd0,  4'd9,  8'd0};
    tv[3] = '{4'd9,  4'd0,  8'd0};
    tv[4] = '{4'd1,  4'd1,  8'd1};
    tv[5] = '{4'd15, 4'd1,  8'd15};
    tv[6] = '{4'd8,  4'd8,  8'd64};
    tv[7] = '{4'd12, 4'd13, 8'd156};

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    reset     = 1'b1;
    step();
    step();
    chk("rst_ready", int'(bus.ready), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_prod", int'(bus.product), 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 8; i++) run_vec(tv[i], $sformatf("vec%0d", i));

    // Start pulses during RUN and DONE must be ignored.
    wait_ready();
    bus.start = 1'b1;
    bus.a     = 4'd2;
    bus.b     = 4'd7;
    step();
    bus.a = 4'd15;
    bus.b = 4'd15;
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.done) ndone++;
      step();
    end
    bus.start = 1'b0;
    chk("ign_ready", int'(bus.ready), 1);
    chk("ign_prod", int'(bus.product), 14);
    for (int i = 0; i < 8; i++) begin
      if (bus.done) ndone++;
      step();
    end
    chk("ign_ndone", ndone, 1);
    chk("ign_prod2", int'(bus.product), 14);

    // Reset during the second RUN cycle aborts.
    bus.start = 1'b1;
    bus.a     = 4'd6;
    bus.b     = 4'd6;
    step();
    bus.start = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_ready", int'(bus.ready), 1);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_prod", int'(bus.product), 0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done) ndone++;
      step();
    end
    chk("abort_ndone", ndone, 0);

    // Reset beats a simultaneous start.
    bus.start = 1'b1;
    bus.a     = 4'd5;
    bus.b     = 4'd5;
    reset     = 1'b1;
    step();
    reset     = 1'b0;
    bus.start = 1'b0;
    chk("rs_ready", int'(bus.ready), 1);
    chk("rs_busy", int'(bus.busy), 0);
    step();
    chk("rs_idle", int'(bus.busy), 0);

    // Exhaustive back-to-back, start on first ready cycle.
    prev_acc = -1;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        wait_ready();
        bus.start = 1'b1;
        bus.a     = 4'(ia);
        bus.b     = 4'(ib);
        acc       = cyc;
        step();
        bus.start = 1'b0;
        bus.a     = 4'(ib);
        bus.b     = 4'(ia);
        if (prev_acc >= 0) chk("ex_spacing", acc - prev_acc, 6);
        prev_acc = acc;
        k = 0;
        while (!bus.done && k < 20) begin
          step();
          k++;
        end
        chk("ex_latency", k, 4);
        pr = 8'(ia * ib);
        chk($sformatf("ex_prod_%0d_%0d", ia, ib), int'(bus.product), int'(pr));
        step();
        chk("ex_stable", int'(bus.product), int'(pr));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
